// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// Default baud timing is derived here so the transmitter and receiver agree.
// The rx state codes are plain 3-bit constants so that older tools,
// which do not read enums, can use them too.
package uart_pkg;

  localparam int UART_CLK_FREQ = 50_000_000;
  localparam int UART_BAUD     = 115_200;
  localparam int DATA_BITS     = 8;

  // Whole clocks per bit period, truncated.
  function automatic int calc_bit_clks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int UART_BIT_CLKS  = calc_bit_clks(UART_CLK_FREQ, UART_BAUD);
  localparam int UART_HALF_CLKS = UART_BIT_CLKS / 2;

  // Receiver states
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous input.
// Both flops reset to 1, which is the idle level of a UART line, so a
// reset never produces a false start edge.
// Ports:
//   clk   - system clock, rising edge
//   rst_b - synchronous reset, active-low
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// UART receiver, 8N1, LSB first, idle-high line.
// The line is synchronized, the start bit is confirmed at its middle, and
// each data bit and the stop bit are sampled at mid-bit. Good bytes are
// written to the RX FIFO; framing errors and overruns are flagged with
// one-cycle pulses.
// Ports:
//   Clk          - system clock, rising edge
//   RstB         - synchronous reset, active-low
//   SerialDataIn - asynchronous serial line, idle high
//   RxFfFull     - RX FIFO full, looked at only when the stop bit is sampled
//   RxFfWrEn     - one-cycle FIFO write strobe
//   RxFfWrData   - received byte, valid while RxFfWrEn is high
//   RxFrameErr   - one-cycle pulse: stop bit sampled low
//   RxOverrun    - one-cycle pulse: good byte dropped because FIFO full
module rx_uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD      = UART_BAUD,
  parameter int BIT_CLKS  = calc_bit_clks(CLK_FREQ, BAUD),
  parameter int HALF_CLKS = BIT_CLKS / 2
) (
  input  logic                 Clk,
  input  logic                 RstB,
  input  logic                 SerialDataIn,
  input  logic                 RxFfFull,
  output logic                 RxFfWrEn,
  output logic [DATA_BITS-1:0] RxFfWrData,
  output logic                 RxFrameErr,
  output logic                 RxOverrun
);

  localparam int CNT_W = $clog2(BIT_CLKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  uart_sync2 u_sync (
    .clk   (Clk),
    .rst_b (RstB),
    .d     (SerialDataIn),
    .q     (rxs)
  );

  // Terminal count of a full bit period; it marks the mid-bit sample point
  // because the count started at the middle of the start bit.
  assign bit_end = (cnt == BIT_LAST);

  // Control: state, counters and the one-cycle output pulses
  always_ff @(posedge Clk) begin
    if (!RstB) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      RxFfWrEn   <= 1'b0;
      RxFfWrData <= '0;
      RxFrameErr <= 1'b0;
      RxOverrun  <= 1'b0;
    end else begin
      RxFfWrEn   <= 1'b0;
      RxFrameErr <= 1'b0;
      RxOverrun  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // A line that is high again at mid-start was only a glitch.
            state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= RX_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rxs) begin
              if (RxFfFull) begin
                RxOverrun <= 1'b1;
              end else begin
                RxFfWrEn   <= 1'b1;
                RxFfWrData <= shreg;
              end
              // Back in IDLE at mid-stop so a following start edge is never missed.
              state <= RX_IDLE;
            end else begin
              RxFrameErr <= 1'b1;
              state      <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_BREAK: begin
          // A held-low line must return high before a new frame can start.
          if (rxs) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Data: shift register, LSB first; every bit is rewritten before use
  always_ff @(posedge Clk) begin
    if (state == RX_DATA && bit_end) begin
      shreg[idx] <= rxs;
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
module tb_rx_uart;

  localparam int BIT_CLKS  = 434;
  localparam int HALF_CLKS = 217;
  localparam int LAT       = 2 + HALF_CLKS + 9 * BIT_CLKS + 1;

  localparam int EV_WR   = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  logic       Clk;
  logic       RstB;
  logic       SerialDataIn;
  logic       RxFfFull;
  logic       RxFfWrEn;
  logic [7:0] RxFfWrData;
  logic       RxFrameErr;
  logic       RxOverrun;

  int unsigned edge_cnt = 0;
  int          multi_hi = 0;
  int          total    = 0;
  int          bad      = 0;
  ev_t         got_q[$];
  ev_t         exp_q[$];

  rx_uart #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (115_200),
    .BIT_CLKS  (BIT_CLKS),
    .HALF_CLKS (HALF_CLKS)
  ) dut (
    .Clk          (Clk),
    .RstB         (RstB),
    .SerialDataIn (SerialDataIn),
    .RxFfFull     (RxFfFull),
    .RxFfWrEn     (RxFfWrEn),
    .RxFfWrData   (RxFfWrData),
    .RxFrameErr   (RxFrameErr),
    .RxOverrun    (RxOverrun)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Monitor: log every output pulse with the index of the edge that raised it
  always @(posedge Clk) begin
    ev_t e;
    edge_cnt = edge_cnt + 1;
    #1;
    if ($countones({RxFfWrEn, RxFrameErr, RxOverrun}) > 1) multi_hi = multi_hi + 1;
    if (RxFfWrEn === 1'b1) begin
      e.kind = EV_WR; e.data = RxFfWrData; e.cyc = edge_cnt; got_q.push_back(e);
    end
    if (RxFrameErr === 1'b1) begin
      e.kind = EV_FERR; e.data = 8'h00; e.cyc = edge_cnt; got_q.push_back(e);
    end
    if (RxOverrun === 1'b1) begin
      e.kind = EV_OVR; e.data = 8'h00; e.cyc = edge_cnt; got_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the outcome of one frame from its stop bit and FIFO state
  function automatic void exp_frame(input logic [7:0] b, input logic stopv, input logic full);
    ev_t e;
    e.cyc = 0;
    if (!stopv) begin
      e.kind = EV_FERR; e.data = 8'h00;
    end else if (full) begin
      e.kind = EV_OVR; e.data = 8'h00;
    end else begin
      e.kind = EV_WR; e.data = b;
    end
    exp_q.push_back(e);
  endfunction

  // Drive one 8N1 frame; called at a falling edge, returns at a falling edge
  // with the line still at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stopv, output int unsigned start);
    SerialDataIn = 1'b0;
    start = edge_cnt;
    repeat (BIT_CLKS) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      SerialDataIn = b[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    SerialDataIn = stopv;
    repeat (BIT_CLKS) @(negedge Clk);
  endtask

  task automatic compare_events(input string tag);
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s.kind%0d", tag, i), got_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s.data%0d", tag, i), got_q[i].data, exp_q[i].data);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_lat(input string tag, input int unsigned start);
    int unsigned lat;
    lat = (got_q.size() > 0) ? got_q[0].cyc - start : 0;
    chk(tag, lat, LAT);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".wren"}, RxFfWrEn, 1'b0);
    chk({tag, ".wrdata"}, RxFfWrData, 8'h00);
    chk({tag, ".ferr"}, RxFrameErr, 1'b0);
    chk({tag, ".ovr"}, RxOverrun, 1'b0);
  endtask

  initial begin
    int unsigned s;
    logic [7:0]  rb;
    logic        rfull;
    logic        rstop;

    RstB         = 1'b0;
    SerialDataIn = 1'b1;
    RxFfFull     = 1'b0;

    // Reset and idle line
    repeat (5) @(negedge Clk);
    chk_reset_outs("reset");
    RstB = 1'b1;
    repeat (5000) @(negedge Clk);
    chk_reset_outs("idle");
    compare_events("idle");

    // Single byte with latency
    send_byte(8'hA5, 1'b1, s);
    exp_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    chk_lat("single.lat", s);
    compare_events("single");
    chk("single.hold", RxFfWrData, 8'hA5);

    // Back-to-back, no idle gap
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h00, 1'b1, s);
    send_byte(8'hFF, 1'b1, s);
    exp_frame(8'hA5, 1'b1, 1'b0);
    exp_frame(8'h00, 1'b1, 1'b0);
    exp_frame(8'hFF, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    compare_events("b2b");

    // Start glitch, then a good byte
    SerialDataIn = 1'b0;
    repeat (100) @(negedge Clk);
    SerialDataIn = 1'b1;
    repeat (1000) @(negedge Clk);
    compare_events("glitch");
    send_byte(8'h3C, 1'b1, s);
    exp_frame(8'h3C, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    chk_lat("after_glitch.lat", s);
    compare_events("after_glitch");

    // Framing error with the line held low for 20 bit times
    send_byte(8'h55, 1'b0, s);
    repeat (20 * BIT_CLKS) @(negedge Clk);
    SerialDataIn = 1'b1;
    repeat (BIT_CLKS) @(negedge Clk);
    exp_frame(8'h55, 1'b0, 1'b0);
    chk_lat("frame.lat", s);
    compare_events("frame");
    send_byte(8'hC3, 1'b1, s);
    exp_frame(8'hC3, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    compare_events("after_frame");

    // Overrun, then the FIFO frees up
    RxFfFull = 1'b1;
    send_byte(8'h81, 1'b1, s);
    RxFfFull = 1'b0;
    exp_frame(8'h81, 1'b1, 1'b1);
    chk_lat("ovr.lat", s);
    compare_events("ovr");
    chk("ovr.hold", RxFfWrData, 8'hC3);
    send_byte(8'h7E, 1'b1, s);
    exp_frame(8'h7E, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    compare_events("after_ovr");

    // Reset during data bit 4 of A5; the transmitter aborts as well
    rb = 8'hA5;
    SerialDataIn = 1'b0;
    repeat (BIT_CLKS) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      SerialDataIn = rb[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    SerialDataIn = rb[4];
    repeat (BIT_CLKS / 3) @(negedge Clk);
    RstB = 1'b0;
    SerialDataIn = 1'b1;
    @(negedge Clk);
    chk_reset_outs("midreset");
    repeat (2) @(negedge Clk);
    RstB = 1'b1;
    repeat (6 * BIT_CLKS) @(negedge Clk);
    chk_reset_outs("midreset.after");
    compare_events("midreset");
    send_byte(8'hA5, 1'b1, s);
    exp_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    chk_lat("after_reset.lat", s);
    compare_events("after_reset");

    // Random frames against the reference model
    for (int r = 0; r < 3; r++) begin
      rb    = 8'($urandom_range(0, 255));
      rfull = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      RxFfFull = rfull;
      send_byte(rb, rstop, s);
      RxFfFull = 1'b0;
      exp_frame(rb, rstop, rfull);
      if (!rstop) begin
        SerialDataIn = 1'b1;
        repeat (BIT_CLKS) @(negedge Clk);
      end
      repeat (4) @(negedge Clk);
      chk_lat($sformatf("rand%0d.lat", r), s);
      compare_events($sformatf("rand%0d", r));
    end

    chk("onehot", multi_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
